// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: radix-2 iterative mult/div unit owning HI/LO, with pipeline stall and flush.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [5:0]       Function_opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             busy,
  output logic             stall,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_MTHI = 6'b010001, F_MTLO = 6'b010011,
                         F_MFHI = 6'b010000, F_MFLO = 6'b010010;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   sh_q, sh_d, k_q, k_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d, sign_quo_q, sign_quo_d, sign_rem_q, sign_rem_d, done_q, done_d;

  logic               is_mul, is_div, is_sgn, is_mthi, is_mtlo, is_mfhi, is_mflo, hilo_op, accept, ge;
  logic [WIDTH-1:0]   abs_a, abs_b, new_rem;
  logic [WIDTH:0]     rem_ext;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;

  assign is_mul  = Function_opcode == F_MULT || Function_opcode == F_MULTU;
  assign is_div  = Function_opcode == F_DIV || Function_opcode == F_DIVU;
  assign is_sgn  = Function_opcode == F_MULT || Function_opcode == F_DIV;
  assign is_mthi = Function_opcode == F_MTHI;
  assign is_mtlo = Function_opcode == F_MTLO;
  assign is_mfhi = Function_opcode == F_MFHI;
  assign is_mflo = Function_opcode == F_MFLO;
  assign hilo_op = is_mul | is_div | is_mthi | is_mtlo | is_mfhi | is_mflo;
  assign accept  = op_valid & ~flush & (state_q == IDLE);

  assign abs_a = (is_sgn & op_a[WIDTH-1]) ? -op_a : op_a;
  assign abs_b = (is_sgn & op_b[WIDTH-1]) ? -op_b : op_b;

  // sh_q shifts out multiplier (mul) or dividend (div) bits MSB first; k_q is the fixed operand
  assign mul_step = {acc_q[2*WIDTH-2:0], 1'b0} + (sh_q[WIDTH-1] ? {{WIDTH{1'b0}}, k_q} : '0);
  assign rem_ext  = {acc_q[2*WIDTH-1:WIDTH], sh_q[WIDTH-1]};
  assign ge       = rem_ext >= {1'b0, k_q};
  assign new_rem  = ge ? rem_ext[WIDTH-1:0] - k_q : rem_ext[WIDTH-1:0];
  assign div_step = {new_rem, acc_q[WIDTH-2:0], ge};
  assign prod     = sign_quo_q ? -acc_q : acc_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      if (accept & (is_mul | is_div)) begin
        state_d    = CALC;
        acc_d      = '0;
        sh_d       = is_div ? abs_a : abs_b;
        k_d        = is_div ? abs_b : abs_a;
        cnt_d      = CW'(WIDTH - 1);
        div_d      = is_div;
        sign_quo_d = is_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        sign_rem_d = is_sgn & op_a[WIDTH-1];
      end
      hi_d = (accept & is_mthi) ? op_a : hi_q;
      lo_d = (accept & is_mtlo) ? op_a : lo_q;
    end else if (flush) begin
      state_d = IDLE;
    end else if (state_q == CALC) begin
      acc_d   = div_q ? div_step : mul_step;
      sh_d    = {sh_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == '0) ? FIX : CALC;
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
      hi_d    = div_q ? (sign_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
      lo_d    = div_q ? (sign_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]) : prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sh_q       <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      div_q      <= 1'b0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign HI         = hi_q;
  assign LO         = lo_q;
  assign busy       = state_q != IDLE;
  assign stall      = op_valid & hilo_op & busy;
  assign done       = done_q;
  assign hilo_rdata = (op_valid & is_mfhi) ? hi_q : (op_valid & is_mflo) ? lo_q : '0;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors; expected HI/LO queued at issue, checked on each done pulse.
module tb_muldiv_sequencer;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_MTHI = 6'b010001, F_MTLO = 6'b010011,
                         F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_ADD = 6'b100000;

  logic        clock, reset, op_valid, flush;
  logic [5:0]  fn;
  logic [31:0] op_a, op_b, HI, LO, hilo_rdata;
  logic        busy, stall, done;

  logic [63:0] exp_q[$];
  logic [63:0] e;
  int checks, errors, done_cnt;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .Function_opcode(fn),
    .op_a(op_a), .op_b(op_b), .flush(flush), .HI(HI), .LO(LO),
    .hilo_rdata(hilo_rdata), .busy(busy), .stall(stall), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done got HI=%h LO=%h expected no done", HI, LO);
      end else begin
        e = exp_q.pop_front();
        chk("result_HI", 64'(HI), 64'(e[63:32]));
        chk("result_LO", 64'(LO), 64'(e[31:0]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    fn = f;
    op_a = a;
    op_b = b;
    step(1);
    op_valid = 1'b0;
    fn = '0;
  endtask

  task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, output int bc);
    exp_q.push_back({ehi, elo});
    present(f, a, b);
    bc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) bc++;
      step(1);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got done=0 expected done within 40 cycles");
    end
    step(1);
  endtask

  initial begin
    int bc, sc, dc;
    reset = 1'b0; op_valid = 1'b0; flush = 1'b0; fn = '0; op_a = '0; op_b = '0;
    checks = 0; errors = 0; done_cnt = 0;
    #12;
    op_valid = 1'b1; fn = F_MFHI;
    #1;
    chk("reset_HI", 64'(HI), 64'h0);
    chk("reset_LO", 64'(LO), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_stall", 64'(stall), 64'h0);
    chk("reset_rdata", 64'(hilo_rdata), 64'h0);
    op_valid = 1'b0; fn = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    step(1);

    run(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, bc);
    chk("multu_busy_cycles", 64'(bc), 64'd33);
    chk("multu_done_single", 64'(done), 64'h0);
    chk("multu_done_count", 64'(done_cnt), 64'd1);
    run(F_MULT, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, bc);
    run(F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, bc);
    run(F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, bc);
    run(F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, bc);
    run(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, bc);

    op_valid = 1'b1; fn = F_MFLO;
    #1 chk("mflo_idle", 64'(hilo_rdata), 64'h80000000);
    fn = F_MFHI;
    #1 chk("mfhi_idle", 64'(hilo_rdata), 64'h0);
    op_valid = 1'b0; fn = '0;
    step(1);

    dc = done_cnt;
    present(F_MTHI, 32'h1234, 32'h0);
    chk("mthi_HI", 64'(HI), 64'h1234);
    chk("mthi_LO_kept", 64'(LO), 64'h80000000);
    chk("mthi_busy", 64'(busy), 64'h0);
    step(2);
    chk("mthi_no_done", 64'(done_cnt), 64'(dc));

    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    present(F_MULT, 32'd3, 32'hFFFFFFFE);
    step(1);
    op_valid = 1'b1; fn = F_ADD;
    #1 chk("nonhilo_no_stall", 64'(stall), 64'h0);
    op_valid = 1'b0; fn = '0;
    step(3);
    op_valid = 1'b1; fn = F_MFHI;
    sc = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) break;
      sc++;
      step(1);
    end
    chk("mfhi_stall_cycles", 64'(sc), 64'd29);
    chk("mfhi_after_stall", 64'(hilo_rdata), 64'hFFFFFFFF);
    chk("done_at_release", 64'(done), 64'h1);
    op_valid = 1'b0; fn = '0;
    step(2);

    present(F_MTHI, 32'hAAAA, 32'h0);
    present(F_MTLO, 32'h5555, 32'h0);
    dc = done_cnt;
    present(F_DIV, 32'd100, 32'd7);
    step(19);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'h0);
    chk("flush_HI", 64'(HI), 64'hAAAA);
    chk("flush_LO", 64'(LO), 64'h5555);
    step(40);
    chk("flush_no_done", 64'(done_cnt), 64'(dc));
    flush = 1'b1;
    present(F_MTHI, 32'hDEAD, 32'h0);
    chk("flush_drops_mthi", 64'(HI), 64'hAAAA);
    present(F_MULT, 32'd2, 32'd2);
    chk("flush_drops_mult", 64'(busy), 64'h0);
    flush = 1'b0;
    step(1);

    present(F_MULT, 32'd5, 32'd6);
    step(9);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_HI", 64'(HI), 64'h0);
    chk("async_reset_LO", 64'(LO), 64'h0);
    chk("async_reset_busy", 64'(busy), 64'h0);
    step(1);
    reset = 1'b1;
    step(1);
    run(F_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, bc);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
